// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
// Holds the FSM state enum, requester count/index width and the rotating-priority pick.
package arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // One-hot pick of the first set request scanning upward from ptr+1, wrapping.
   // Scanning from the farthest slot to the nearest lets the nearest overwrite.
   function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                  input logic [IDX_W-1:0]   ptr);
      logic [NUM_REQ-1:0] pick;
      logic [IDX_W-1:0]   idx;
      pick = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = ptr + IDX_W'(k);
         if (req[idx]) begin
            pick      = '0;
            pick[idx] = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/onehot_enc4.sv
// Combinational 4-bit one-hot to 2-bit binary index encoder.
// An all-zero input encodes to 2'b00.
module onehot_enc4
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] oh,
   output logic [IDX_W-1:0]   idx
);

   assign idx = {oh[3] | oh[2], oh[3] | oh[1]};

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant and held ownership.
// Define RR_ARBITER4_TIMEOUT_EN to bound ownership at HOLD_MAX cycles with a timeout pulse.
//
// Handshake: a requester owns the grant from the cycle gnt[i] rises until it either
// drops req[i] or strobes done; release takes effect on the next edge, followed by
// exactly one IDLE cycle in which the next owner is chosen.
module rr_arbiter4
   import arb_pkg::*;
#(
   parameter int HOLD_MAX = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid,
   output logic               timeout
);

   generate
      if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_range
         $error("rr_arbiter4: HOLD_MAX must lie in 2..255");
      end
   endgenerate

   arb_state_t         state, state_n;
   logic [IDX_W-1:0]   ptr, ptr_n;
   logic [NUM_REQ-1:0] gnt_n;
   logic [IDX_W-1:0]   idx_n;
   logic               timeout_n;

`ifdef RR_ARBITER4_TIMEOUT_EN
   logic [7:0]         hold_cnt, hold_cnt_n;
`endif

   // Index of the next grant feeds both the gnt_idx register and the pointer.
   onehot_enc4 u_enc (
      .oh  (gnt_n),
      .idx (idx_n)
   );

   always_comb begin
      state_n   = state;
      gnt_n     = gnt;
      ptr_n     = ptr;
      timeout_n = 1'b0;
`ifdef RR_ARBITER4_TIMEOUT_EN
      hold_cnt_n = hold_cnt;
`endif
      case (state)
         IDLE: begin
            gnt_n = '0;
            if (|req) begin
               gnt_n   = rr_pick(req, ptr);
               state_n = GRANT;
               ptr_n   = idx_n;
`ifdef RR_ARBITER4_TIMEOUT_EN
               hold_cnt_n = '0;
`endif
            end
         end
         GRANT: begin
            // Natural release wins over a timeout landing in the same cycle.
            if (done || !req[gnt_idx]) begin
               state_n = IDLE;
               gnt_n   = '0;
            end
`ifdef RR_ARBITER4_TIMEOUT_EN
            else if (hold_cnt == 8'(HOLD_MAX - 1)) begin
               state_n   = IDLE;
               gnt_n     = '0;
               timeout_n = 1'b1;
            end else begin
               hold_cnt_n = hold_cnt + 8'd1;
            end
`endif
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 2'd3;
         gnt       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
`ifdef RR_ARBITER4_TIMEOUT_EN
         hold_cnt  <= '0;
`endif
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         gnt       <= gnt_n;
         gnt_idx   <= idx_n;
         gnt_valid <= |gnt_n;
         timeout   <= timeout_n;
`ifdef RR_ARBITER4_TIMEOUT_EN
         hold_cnt  <= hold_cnt_n;
`endif
      end
   end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed scenarios plus random traffic,
// every cycle compared against an owner/pointer reference model.
module tb_rr_arbiter4;

   localparam int HOLD_MAX = 4;
`ifdef RR_ARBITER4_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state: owner -1 means nobody holds the grant
   int m_owner;
   int m_ptr;
   int m_held;
   bit m_timeout;

   rr_arbiter4 #(.HOLD_MAX(HOLD_MAX)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // one edge of the reference model, using the inputs the DUT just sampled
   task automatic model_step();
      bit found;
      int c;
      m_timeout = 1'b0;
      if (rst) begin
         m_owner = -1;
         m_ptr   = 3;
         m_held  = 0;
      end else if (m_owner < 0) begin
         found = 1'b0;
         for (int k = 1; k <= 4; k++) begin
            c = (m_ptr + k) % 4;
            if (!found && req[c]) begin
               found   = 1'b1;
               m_owner = c;
               m_ptr   = c;
               m_held  = 1;
            end
         end
      end else if (done || !req[m_owner]) begin
         m_owner = -1;
      end else if (TO_EN && m_held >= HOLD_MAX) begin
         m_owner   = -1;
         m_timeout = 1'b1;
      end else begin
         m_held++;
      end
   endtask

   task automatic compare_outputs();
      logic [3:0] e_gnt;
      e_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      check("gnt", 32'(gnt), 32'(e_gnt));
      check("gnt_idx", 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
      check("timeout", 32'(timeout), 32'(m_timeout));
   endtask

   // driver: apply inputs away from the edge, advance one clock, then compare
   task automatic drive(input logic [3:0] r, input logic d, input logic rs);
      req  = r;
      done = d;
      rst  = rs;
      @(posedge clk);
      model_step();
      #1;
      compare_outputs();
   endtask

   task automatic do_reset();
      drive(4'b0000, 1'b0, 1'b1);
      drive(4'b0000, 1'b0, 1'b1);
   endtask

   logic [3:0] order [5];
   logic [3:0] rq;
   logic       dn;
   logic       rs;

   initial begin
      order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
      order[3] = 4'b1000; order[4] = 4'b0001;
      req = '0; done = 1'b0; rst = 1'b1;
      m_owner = -1; m_ptr = 3; m_held = 0; m_timeout = 1'b0;

      do_reset();
      check("reset_gnt", 32'(gnt), 32'd0);

      // req 0101: requester 0 first, then after done one IDLE and requester 2
      drive(4'b0101, 1'b0, 1'b0);
      check("s1_first_gnt", 32'(gnt), 32'h1);
      drive(4'b0101, 1'b1, 1'b0);
      check("s1_idle_gap", 32'(gnt_valid), 32'd0);
      drive(4'b0101, 1'b0, 1'b0);
      check("s1_second_gnt", 32'(gnt), 32'h4);
      check("s1_second_idx", 32'(gnt_idx), 32'd2);
      drive(4'b0000, 1'b0, 1'b0);

      // all four requesting, done on every 3rd GRANT cycle
      do_reset();
      for (int g = 0; g < 5; g++) begin
         drive(4'b1111, 1'b0, 1'b0);
         check("rr_order", 32'(gnt), 32'(order[g]));
         drive(4'b1111, 1'b0, 1'b0);
         drive(4'b1111, 1'b0, 1'b0);
         drive(4'b1111, 1'b1, 1'b0);
      end

      // owner 1 drops its request mid-grant while requester 3 waits
      do_reset();
      drive(4'b1010, 1'b0, 1'b0);
      check("s3_owner1", 32'(gnt), 32'h2);
      drive(4'b1010, 1'b0, 1'b0);
      drive(4'b1000, 1'b0, 1'b0);
      drive(4'b1000, 1'b0, 1'b0);
      check("s3_owner3", 32'(gnt), 32'h8);

      // single requester held without done: bounded only in the timeout build
      do_reset();
      for (int i = 0; i < 14; i++) drive(4'b0010, 1'b0, 1'b0);

      // reset during GRANT drops the grant, then requester 3 wins again
      do_reset();
      drive(4'b1000, 1'b0, 1'b0);
      drive(4'b1000, 1'b0, 1'b0);
      drive(4'b1000, 1'b0, 1'b1);
      check("s5_rst_gnt", 32'(gnt), 32'd0);
      check("s5_rst_to", 32'(timeout), 32'd0);
      drive(4'b1000, 1'b0, 1'b0);
      check("s5_regrant", 32'(gnt), 32'h8);

      // done and request drop together: one release, no timeout
      drive(4'b0000, 1'b1, 1'b0);
      check("s6_release", 32'(gnt), 32'd0);
      drive(4'b0000, 1'b1, 1'b0);

      // random traffic with sticky requests, occasional done and rare reset
      rq = 4'($urandom_range(0, 15));
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
         dn = ($urandom_range(0, 4) == 0);
         rs = ($urandom_range(0, 60) == 0);
         drive(rq, dn, rs);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
